// File: rtl/act_skew_feeder.sv
// ---------------------------------------------------------------------------
// act_skew_feeder
//
// Sits between the activation buffer read port and the left edge of the
// MUL_SIZE x MUL_SIZE systolic array. Each accepted row is released as a
// diagonal wavefront: lane i is delayed i cycles relative to lane 0. When the
// row flagged in_last is accepted, the skew chains are drained with bubbles.
// done pulses in the cycle the last row's final lane is presented.
//
// Handshake: a row transfers on a rising edge where in_valid && in_ready.
// in_ready is a function of state and stall only, never of in_valid. Once
// in_valid is raised, in_data/in_last are held until the transfer happens.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        input row valid
//   in_ready        block can accept a row this cycle
//   in_data         row; lane i = bits [i*DATA_W +: DATA_W]
//   in_last         marks the accepted row as last of the tile
//   stall           array stall; freezes all state
//   out_data        skewed lane data to the array
//   out_lane_valid  per-lane valid, travels with the data
//   busy            high in STREAM or DRAIN
//   done            one-cycle pulse at tile completion
//   rows_accepted   rows accepted in the current tile (saturating)
//   dbg_state       current FSM state (0 IDLE, 1 STREAM, 2 DRAIN)
// ---------------------------------------------------------------------------
module act_skew_feeder #(
    parameter int MUL_SIZE = 32,
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MUL_SIZE*DATA_W-1:0] in_data,
    input  logic                       in_last,
    input  logic                       stall,
    output logic [MUL_SIZE*DATA_W-1:0] out_data,
    output logic [MUL_SIZE-1:0]        out_lane_valid,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           rows_accepted,
    output logic [1:0]                 dbg_state
);

    localparam int DW = $clog2(MUL_SIZE);
    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(MUL_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] rows_q, rows_d;
    logic             acc;

    assign in_ready = !stall && ((state_q == S_IDLE) || (state_q == S_STREAM));
    assign acc      = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            drain_q <= '0;
            rows_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            rows_q  <= rows_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        rows_d  = rows_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    // First row of a new tile restarts the count at 1.
                    rows_d = CNT_ONE;
                    if (in_last) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (acc) begin
                    rows_d = (rows_q == '1) ? rows_q : rows_q + CNT_ONE;
                    if (in_last) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                // drain_cnt == 0 is the cycle the last row sits on the
                // deepest lane; a stall defers done to the next free cycle.
                if (!stall) begin
                    if (drain_q == '0) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign rows_accepted = rows_q;
    assign dbg_state     = state_q;

    // ------------------------------------------------------------------
    // Skew chains: lane i is a shift register of depth i+1. Non-accepting
    // unstalled cycles inject a zero bubble at every chain head.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < MUL_SIZE; gi++) begin : g_lane
        logic [DATA_W-1:0] d_q [0:gi];
        logic              v_q [0:gi];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= gi; j++) begin
                    d_q[j] <= '0;
                    v_q[j] <= 1'b0;
                end
            end else if (!stall) begin
                d_q[0] <= acc ? in_data[gi*DATA_W +: DATA_W] : '0;
                v_q[0] <= acc;
                for (int j = 1; j <= gi; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end

        assign out_data[gi*DATA_W +: DATA_W] = d_q[gi];
        assign out_lane_valid[gi]            = v_q[gi];
    end

endmodule

// File: doc/act_skew_feeder.md
Name: act_skew_feeder

Overview:
- Sits between the activation (unified) buffer read port and the left edge of the MUL_SIZE x MUL_SIZE systolic array.
- Accepts one full activation row per handshake and emits it diagonally skewed: lane i is delayed i cycles relative to lane 0. This gives the staircase wavefront the array requires.
- Tracks the end of a tile and drains the skew pipeline with bubbles.
- Issues a done pulse when the last row's final lane has left.

Parameters:
- MUL_SIZE, 32, number of lanes (array rows); must be >= 2.
- DATA_W, 16, activation width per lane (matches act_t).
- CNT_W, 16, width of the row counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input row valid.
- in_ready  out  1  block can accept a row this cycle.
- in_data  in  MUL_SIZE*DATA_W  row; lane i = bits [i*DATA_W +: DATA_W].
- in_last  in  1  qualifies the accepted row as the last of the tile.
- stall  in  1  array stall; freezes all state.
- out_data  out  MUL_SIZE*DATA_W  skewed lanes to the array.
- out_lane_valid  out  MUL_SIZE  per-lane valid.
- busy  out  1  high in STREAM or DRAIN.
- done  out  1  one-cycle pulse at tile completion.
- rows_accepted  out  CNT_W  rows accepted in the current tile.

Behaviour:
- Reset (async, immediate):
  - All lane registers and out_data = 0.
  - out_lane_valid = 0, done = 0, rows_accepted = 0.
  - State = IDLE.
  - Reset mid-tile discards in-flight data; no done is issued.
- Accept condition: acc = in_valid & in_ready.
  - in_ready = !stall & (state == IDLE | state == STREAM).
  - in_ready is combinational. It must not depend on in_valid.
- Skew pipeline: lane i is a shift chain of depth i+1.
  - A row accepted at edge k appears on lane i during cycle k+1+i. Lane 0 latency = 1, lane MUL_SIZE-1 latency = MUL_SIZE.
  - out_lane_valid[i] travels with the data.
  - Each non-stalled cycle without acceptance injects data 0, valid 0 at the head of every chain (a bubble). Bubbles propagate diagonally like data.
- Stall: when stall = 1, nothing advances.
  - No shift, no counter change, no state change.
  - Outputs hold their values; done does not assert.
  - done in progress: if done would fire in the stalled cycle, it fires in the first unstalled cycle instead.
- State machine:
  - IDLE: on acc, go to STREAM and set rows_accepted = 1. If in_last is also set on that row, go directly to DRAIN.
  - STREAM: each acc increments rows_accepted, saturating at 2^CNT_W-1. On acc & in_last, go to DRAIN and load drain_cnt = MUL_SIZE-1.
  - DRAIN: in_ready = 0. drain_cnt decrements each unstalled cycle. When drain_cnt = 0 and the cycle is unstalled, go to IDLE.
- done: asserts in exactly the cycle in which out_lane_valid[MUL_SIZE-1] carries the last row. This is the unstalled DRAIN cycle with drain_cnt = 0, which is MUL_SIZE cycles after the in_last acceptance edge.
- rows_accepted:
  - Holds its value through IDLE after done, so software can read it.
  - Cleared to 1 (not 0) on the first acc of the next tile.
- busy = (state != IDLE).
- Back-to-back tiles: a new tile cannot be accepted until the FSM returns to IDLE. The minimum gap between the in_last acceptance and the next accept is MUL_SIZE cycles.
- in_last with in_valid = 0 is ignored.

Test Plan:
- Single row: MUL_SIZE=32; reset, then send one row with lane i = i+1 and in_last = 1 at edge 0.
  - Expect lane i = i+1 with valid in cycle 1+i.
  - Expect done in cycle 32.
  - Expect rows_accepted = 1 and busy low from cycle 33.
- Stream of 4 rows: rows r = 0..3, lane value = 256*r + i, sent back-to-back, in_last on r = 3.
  - Expect lane 5 to show 5, 261, 517, 773 in cycles 6–9.
  - Expect done in cycle 35 and rows_accepted = 4.
- Bubble: send row A (all 0xAAAA), then in_valid low for 1 cycle, then row B (0xBBBB) with in_last.
  - Expect lane 10 to show A in cycle 11, valid = 0 in cycle 12, and B in cycle 13.
- Stall mid-drain: single row with in_last; assert stall during cycles 10–12.
  - Expect outputs frozen over those 3 cycles.
  - Expect done delayed to cycle 35.
  - Expect in_ready low throughout.
- Reset mid-tile: accept 3 rows, then pulse rst for 1 cycle.
  - Expect all out_lane_valid = 0 immediately, no done, state IDLE, rows_accepted = 0.
  - Expect in_ready = 1 in the next cycle.
- Back-pressure in DRAIN: hold in_valid high with new data after in_last.
  - Expect in_ready = 0 for 32 cycles (through the done cycle), then acceptance in cycle 33 with rows_accepted = 1.
